mips_multi_ctrl: RTL and testbench

MIPS_MULTI_CTRL -- requirements
Module: mips_multi_ctrl

---
 rtl/mips_multi_ctrl_if.sv | 31 +++
 rtl/mips_multi_ctrl.sv | 137 +++++++++++++
 tb/tb_mips_multi_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multi_ctrl_if.sv
// Control-unit bundle: instruction fields and ALU flag in, datapath controls and debug state out.
// master = controller side, slave = datapath side.
interface mips_multi_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       pcen;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, state
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, state
  );
endinterface

// File: rtl/mips_multi_ctrl.sv
// Multicycle MIPS control FSM (lw, sw, R-type, beq, addi, j).
// Controls are registered alongside the state; only pcen sees the zero flag combinationally.
module mips_multi_ctrl (
  input  logic             clk,
  input  logic             reset,
  mips_multi_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcwrite;
    logic       branch;
  } ctl_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Control word for a given state; funct only matters when aluop selects the R-type decode.
  function automatic ctl_t decode(input state_t s, input logic [5:0] f);
    ctl_t       c;
    logic [1:0] aluop;
    c     = '0;
    aluop = 2'b00;
    case (s)
      FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      EXECUTE: begin c.alusrca = 1'b1; aluop = 2'b10; end
      ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BRANCH:  begin c.alusrca = 1'b1; aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
    case (aluop)
      2'b01: c.alucontrol = 3'b110;
      2'b10: begin
        case (f)
          6'b100000: c.alucontrol = 3'b010;
          6'b100010: c.alucontrol = 3'b110;
          6'b100100: c.alucontrol = 3'b000;
          6'b100101: c.alucontrol = 3'b001;
          6'b101010: c.alucontrol = 3'b111;
          default:   c.alucontrol = 3'b010;
        endcase
      end
      default: c.alucontrol = 3'b010;
    endcase
    return c;
  endfunction

  state_t state_reg;
  state_t state_next;
  ctl_t   ctl_reg;
  ctl_t   ctl_next;

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:   state_next = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_next = MEMWB;
      EXECUTE: state_next = ALUWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  always_comb ctl_next = decode(state_next, bus.funct);

  // Outputs are loaded with the state they belong to, so they stay purely Moore.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH;
      ctl_reg   <= decode(FETCH, 6'd0);
    end else begin
      state_reg <= state_next;
      ctl_reg   <= ctl_next;
    end
  end

  assign bus.iord       = ctl_reg.iord;
  assign bus.memwrite   = ctl_reg.memwrite;
  assign bus.irwrite    = ctl_reg.irwrite;
  assign bus.regwrite   = ctl_reg.regwrite;
  assign bus.regdst     = ctl_reg.regdst;
  assign bus.memtoreg   = ctl_reg.memtoreg;
  assign bus.alusrca    = ctl_reg.alusrca;
  assign bus.alusrcb    = ctl_reg.alusrcb;
  assign bus.pcsrc      = ctl_reg.pcsrc;
  assign bus.alucontrol = ctl_reg.alucontrol;
  assign bus.pcen       = ctl_reg.pcwrite | (ctl_reg.branch & bus.zero);
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Bench for mips_multi_ctrl: instruction-level reference model, per-cycle compare, directed corner cases.
module tb_mips_multi_ctrl;

  typedef int iq_t[$];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multi_ctrl_if bus();

  mips_multi_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic       exp_valid = 1'b0;
  int         exp_state = 0;
  int         rw_total = 0;
  int         mw_total = 0;
  logic [2:0] obs_exec_alu = 3'b000;
  logic       obs_branch_pcen = 1'b0;
  logic [1:0] obs_branch_pcsrc = 2'b00;
  logic       obs_lw_iord_ok = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU code required for an R-type funct.
  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // State walk of one instruction, starting and ending in FETCH.
  function automatic iq_t seq_of(input logic [5:0] op);
    case (op)
      6'b100011: return '{0, 1, 2, 3, 4};
      6'b101011: return '{0, 1, 2, 5};
      6'b000000: return '{0, 1, 6, 7};
      6'b001000: return '{0, 1, 9, 10};
      6'b000100: return '{0, 1, 8};
      6'b000010: return '{0, 1, 11};
      default:   return '{0, 1};
    endcase
  endfunction

  // {iord,memwrite,irwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,alucontrol,pcen}
  function automatic logic [14:0] exp_out(input int st, input logic [5:0] f, input logic z);
    logic iord, mw, irw, rw, rd, m2r, asa, pcen;
    logic [1:0] asb, pcs;
    logic [2:0] ac;
    {iord, mw, irw, rw, rd, m2r, asa, pcen} = 8'b0;
    asb = 2'b00; pcs = 2'b00; ac = 3'b010;
    case (st)
      0:  begin irw = 1; pcen = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; ac = alu_of_funct(f); end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; ac = 3'b110; pcs = 2'b01; pcen = z; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {iord, mw, irw, rw, rd, m2r, asa, asb, pcs, ac, pcen};
  endfunction

  function automatic int exp_rw(input logic [5:0] op);
    return (op == 6'b100011 || op == 6'b000000 || op == 6'b001000) ? 1 : 0;
  endfunction

  function automatic int exp_mw(input logic [5:0] op);
    return (op == 6'b101011) ? 1 : 0;
  endfunction

  // zmode: 0/1 forces zero, anything else randomizes it each cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode);
    iq_t q;
    int  rw0, mw0;
    q   = seq_of(op);
    rw0 = rw_total;
    mw0 = mw_total;
    bus.op    = op;
    bus.funct = f;
    exp_valid = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      exp_state = q[i];
      bus.zero  = (zmode == 0 || zmode == 1) ? 1'(zmode) : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    exp_state = 0;
    chk($sformatf("regwrite_cycles op=%b", op), rw_total - rw0, exp_rw(op));
    chk($sformatf("memwrite_cycles op=%b", op), mw_total - mw0, exp_mw(op));
    $display("instr op=%b funct=%b cycles=%0d", op, f, q.size());
  endtask

  task automatic wait_fetch(input string name);
    int n;
    n = 0;
    while (bus.state != 4'd0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, {31'b0, bus.state == 4'd0}, 32'd1);
  endtask

  logic [5:0] op_tab [7];
  logic [5:0] fn_tab [6];

  initial begin
    op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
    reset     = 1'b1;
    bus.op    = 6'b000000;
    bus.funct = 6'h20;
    bus.zero  = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (exp_valid) begin
          chk("state", {28'b0, bus.state}, exp_state);
          chk($sformatf("outputs st=%0d", exp_state),
              {bus.iord, bus.memwrite, bus.irwrite, bus.regwrite, bus.regdst, bus.memtoreg,
               bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.pcen},
              exp_out(exp_state, bus.funct, bus.zero));
          chk("memwrite_irwrite_exclusive", {31'b0, bus.memwrite & bus.irwrite}, 32'd0);
          rw_total += int'(bus.regwrite);
          mw_total += int'(bus.memwrite);
          if (bus.state == 4'd6) obs_exec_alu = bus.alucontrol;
          if (bus.state == 4'd8) begin
            obs_branch_pcen  = bus.pcen;
            obs_branch_pcsrc = bus.pcsrc;
          end
          if (bus.op == 6'b100011 && bus.iord && bus.state != 4'd3) obs_lw_iord_ok = 1'b0;
        end
      end
    join_none

    // Reset state with literal FETCH values.
    #12;
    chk("reset_state", {28'b0, bus.state}, 32'd0);
    chk("reset_irwrite", {31'b0, bus.irwrite}, 32'd1);
    chk("reset_pcen", {31'b0, bus.pcen}, 32'd1);
    chk("reset_alusrcb", {30'b0, bus.alusrcb}, 32'd1);
    chk("reset_alucontrol", {29'b0, bus.alucontrol}, 32'd2);
    chk("reset_memwrite", {31'b0, bus.memwrite}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("first_edge_decode", {28'b0, bus.state}, 32'd1);
    wait_fetch("settle_after_reset");

    // Directed cases with literal pins.
    run_instr(6'b100011, 6'h20, 2);
    chk("pin_lw_iord_only_memrd", {31'b0, obs_lw_iord_ok}, 32'd1);
    run_instr(6'b101011, 6'h20, 2);
    run_instr(6'b000000, 6'h2a, 2);
    chk("pin_slt_alucontrol", {29'b0, obs_exec_alu}, 32'd7);
    run_instr(6'b000000, 6'h3f, 2);
    chk("pin_unknown_funct_alucontrol", {29'b0, obs_exec_alu}, 32'd2);
    run_instr(6'b000100, 6'h20, 1);
    chk("pin_beq_taken_pcen", {31'b0, obs_branch_pcen}, 32'd1);
    chk("pin_beq_pcsrc", {30'b0, obs_branch_pcsrc}, 32'd1);
    run_instr(6'b000100, 6'h20, 0);
    chk("pin_beq_not_taken_pcen", {31'b0, obs_branch_pcen}, 32'd0);
    run_instr(6'b001000, 6'h20, 2);
    run_instr(6'b000010, 6'h20, 2);
    run_instr(6'b111111, 6'h20, 2);

    // Asynchronous reset while in MEMWR.
    bus.op    = 6'b101011;
    bus.funct = 6'h20;
    for (int i = 0; i < 3; i++) begin
      exp_state = (i == 0) ? 0 : ((i == 1) ? 1 : 2);
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
    chk("memwr_reached", {28'b0, bus.state}, 32'd5);
    chk("memwr_memwrite", {31'b0, bus.memwrite}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_state", {28'b0, bus.state}, 32'd0);
    chk("async_reset_memwrite", {31'b0, bus.memwrite}, 32'd0);
    chk("async_reset_irwrite", {31'b0, bus.irwrite}, 32'd1);
    chk("async_reset_pcen", {31'b0, bus.pcen}, 32'd1);
    chk("async_reset_alucontrol", {29'b0, bus.alucontrol}, 32'd2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_decode", {28'b0, bus.state}, 32'd1);
    wait_fetch("settle_after_mid_reset");

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, f;
      op = op_tab[$urandom_range(0, 6)];
      if (op == 6'b111111) op = 6'($urandom_range(0, 63));
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fn_tab[$urandom_range(0, 5)];
      run_instr(op, f, 2);
    end

    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
